updown_sweep_ctrl: RTL
======================

UPDOWN_SWEEP_CTRL -- requirements
Module: updown_sweep_ctrl

Interface
REQ-001 Parameter: WIDTH, default 4, counter and bound width in bits.
REQ-002 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: start  input  1  request a sweep; sampled only in IDLE.
REQ-005 Port: abort  input  1  terminate an active sweep.
REQ-006 Port: lo  input  WIDTH  lower sweep bound; sampled with start.
REQ-007 Port: hi  input  WIDTH  upper sweep bound; sampled with start.
REQ-008 Port: reps  input  4  number of up/down passes; sampled with start; 0 is treated as 1.
REQ-009 Port: q  output  WIDTH  current counter value.
REQ-010 Port: dir  output  1  count direction, 1 = up, 0 = down.
REQ-011 Port: busy  output  1  high while in UP or DOWN.
REQ-012 Port: done  output  1  one-cycle pulse on normal completion.
REQ-013 Port: err  output  1  one-cycle pulse on a rejected start.

Function
REQ-014 The FSM SHALL have exactly the states IDLE, UP, DOWN and DONE.
REQ-015 In IDLE with start=1 and lo<hi, the block SHALL latch lo, hi and reps, load q=lo, set dir=1 and enter UP on the next edge.
REQ-016 In IDLE with start=1 and lo>=hi, the block SHALL pulse err for the next cycle, remain in IDLE and leave q unchanged.
REQ-017 In UP, q SHALL increment by 1 each cycle; in the cycle where q==hi, the next state SHALL be DOWN with q=hi-1 and dir=0.
REQ-018 In DOWN, q SHALL decrement by 1 each cycle; in the cycle where q==lo, the pass count SHALL increment.
REQ-019 If passes remain after REQ-018, the next state SHALL be UP with q=lo+1 and dir=1; otherwise the next state SHALL be DONE with q held at lo.
REQ-020 DONE SHALL last exactly one cycle with done=1 and busy=0, then return to IDLE.
REQ-021 abort=1 in UP or DOWN SHALL force IDLE on the next edge with q held, busy=0 and no done pulse; abort SHALL be ignored in IDLE and DONE.
REQ-022 If abort and start are both high in IDLE, start SHALL be honoured.
REQ-023 start SHALL be ignored outside IDLE, and bound or reps changes SHALL NOT affect an active sweep.
REQ-024 q SHALL never wrap: lo<hi keeps every value within [lo, hi].
REQ-025 In IDLE, q SHALL hold its last value and dir SHALL hold its last value.

Reset
REQ-026 With reset=1 at a clock edge, the next state SHALL be IDLE with q=0, dir=1, busy=0, done=0, err=0 and the pass count 0, regardless of state or other inputs.
REQ-027 Reset SHALL take priority over start and abort; a sweep interrupted by reset SHALL NOT produce a done pulse.

Structure
REQ-028 State encoding (enum IDLE/UP/DOWN/DONE) and the default WIDTH SHALL live in shared package updown_ctrl_pkg.
REQ-029 Counting SHALL be done by one sub-module, updown_cnt, a WIDTH-bit synchronous counter with inputs en, select (1=up), load and load_val, and synchronous active-high reset; the FSM SHALL drive its controls.

Verification
REQ-030 Scenario: reset, then start with lo=2, hi=4, reps=1 -> q on successive cycles reads 2, 3, 4, 3, 2, then the DONE cycle holds q=2 with done=1, then IDLE.
REQ-031 Scenario: lo=0, hi=1, reps=2 -> q reads 0, 1, 0, 1, 0; exactly one done pulse; dir toggles at each bound.
REQ-032 Scenario: start with lo=5, hi=5 and with lo=9, hi=3 -> err pulses for one cycle each, busy stays 0 and q is unchanged.
REQ-033 Scenario: abort while q=6 in UP (lo=3, hi=10) -> next cycle IDLE, q=6, busy=0, no done pulse.
REQ-034 Scenario: reset asserted mid-DOWN with lo=1, hi=14 -> next cycle q=0, dir=1 and all flags 0; a new start then behaves per REQ-015.
REQ-035 Scenario: reps=0 and start pulsed during busy -> one pass only, and the mid-sweep start is ignored.

Source files
------------

// File: rtl/updown_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// updown_ctrl_pkg
// Shared definitions for the up/down sweep controller:
//   - state_e       : controller state encoding (IDLE/UP/DOWN/DONE)
//   - DEFAULT_WIDTH : default counter / bound width in bits
//   - REPS_W        : width of the reps request and of the pass counter
//   - eff_reps()    : maps a reps request to the number of passes to run
// -----------------------------------------------------------------------------
package updown_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 4;
  localparam int REPS_W        = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // A request for zero passes still runs one full up/down pass.
  function automatic logic [REPS_W-1:0] eff_reps(input logic [REPS_W-1:0] reps);
    return (reps == '0) ? REPS_W'(1) : reps;
  endfunction

endpackage

// File: rtl/updown_cnt.sv
// -----------------------------------------------------------------------------
// updown_cnt
// WIDTH-bit synchronous up/down counter with synchronous load.
// Ports:
//   clk      : clock, all updates on rising edge
//   reset    : synchronous active-high reset, clears q to 0
//   en       : count enable
//   select   : count direction, 1 = up, 0 = down
//   load     : load load_val into q (takes priority over en)
//   load_val : value loaded when load is high
//   q        : counter value
// The counter itself wraps modulo 2**WIDTH; keeping q inside the sweep
// bounds is the controlling FSM's job.
// -----------------------------------------------------------------------------
module updown_cnt
  import updown_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             select,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en) begin
      cnt_d = select ? (cnt_q + WIDTH'(1)) : (cnt_q - WIDTH'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/updown_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// updown_sweep_ctrl
// Sweeps a counter from lo up to hi and back down to lo, repeated for a
// requested number of passes, then pulses done for one cycle.
// Ports:
//   clk         : clock, all state changes on rising edge
//   reset       : synchronous active-high reset (priority over all inputs)
//   start       : sweep request, only sampled in IDLE
//   abort       : terminates an active sweep (UP/DOWN) on the next edge
//   lo, hi      : sweep bounds, sampled with an accepted start (need lo < hi)
//   reps        : number of up/down passes, sampled with start, 0 means 1
//   q           : current counter value
//   dir         : count direction, 1 = up, 0 = down
//   busy        : high while in UP or DOWN
//   done        : one-cycle pulse in the DONE state after a normal finish
//   err         : one-cycle pulse the cycle after a rejected start (lo >= hi)
//   dbg_state_o : current FSM state, for observation only
//
// Request semantics: start is a level sampled on each rising edge while the
// FSM is in IDLE; there is no ready/ack. An accepted start shows up as busy=1
// on the next cycle, a rejected one as err=1 on the next cycle. start is
// ignored in every other state, and bounds/reps are only read when accepted.
// -----------------------------------------------------------------------------
module updown_sweep_ctrl
  import updown_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [WIDTH-1:0]  lo,
  input  logic [WIDTH-1:0]  hi,
  input  logic [REPS_W-1:0] reps,
  output logic [WIDTH-1:0]  q,
  output logic              dir,
  output logic              busy,
  output logic              done,
  output logic              err,
  output state_e            dbg_state_o
);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  lo_q, lo_d;
  logic [WIDTH-1:0]  hi_q, hi_d;
  logic [REPS_W-1:0] reps_q, reps_d;
  logic [REPS_W-1:0] pass_q, pass_d;
  logic              dir_q, dir_d;
  logic              err_q, err_d;

  logic              cnt_en;
  logic              cnt_up;
  logic              cnt_load;
  logic [WIDTH-1:0]  cnt_load_val;
  logic [WIDTH-1:0]  cnt_val;
  logic [REPS_W-1:0] pass_inc;

  updown_cnt #(
    .WIDTH (WIDTH)
  ) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .en       (cnt_en),
    .select   (cnt_up),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .q        (cnt_val)
  );

  // Pass counter after completing the current down leg; never exceeds
  // reps_q (<= 15), so it cannot overflow.
  assign pass_inc = pass_q + REPS_W'(1);

  always_comb begin
    state_d      = state_q;
    lo_d         = lo_q;
    hi_d         = hi_q;
    reps_d       = reps_q;
    pass_d       = pass_q;
    dir_d        = dir_q;
    err_d        = 1'b0;
    cnt_en       = 1'b0;
    cnt_up       = 1'b1;
    cnt_load     = 1'b0;
    cnt_load_val = lo;

    unique case (state_q)
      ST_IDLE: begin
        // abort has no meaning here; start wins when both are high.
        if (start) begin
          if (lo < hi) begin
            lo_d         = lo;
            hi_d         = hi;
            reps_d       = eff_reps(reps);
            pass_d       = '0;
            cnt_load     = 1'b1;
            cnt_load_val = lo;
            dir_d        = 1'b1;
            state_d      = ST_UP;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      ST_UP: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (cnt_val == hi_q) begin
          // Turn around at the top: next value is hi-1.
          cnt_en  = 1'b1;
          cnt_up  = 1'b0;
          dir_d   = 1'b0;
          state_d = ST_DOWN;
        end else begin
          cnt_en = 1'b1;
          cnt_up = 1'b1;
        end
      end

      ST_DOWN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (cnt_val == lo_q) begin
          pass_d = pass_inc;
          if (pass_inc < reps_q) begin
            // Next pass starts at lo+1; lo itself was just shown.
            cnt_en  = 1'b1;
            cnt_up  = 1'b1;
            dir_d   = 1'b1;
            state_d = ST_UP;
          end else begin
            // Counter holds lo through DONE.
            state_d = ST_DONE;
          end
        end else begin
          cnt_en = 1'b1;
          cnt_up = 1'b0;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      lo_q    <= '0;
      hi_q    <= '0;
      reps_q  <= '0;
      pass_q  <= '0;
      dir_q   <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      reps_q  <= reps_d;
      pass_q  <= pass_d;
      dir_q   <= dir_d;
      err_q   <= err_d;
    end
  end

  assign q           = cnt_val;
  assign dir         = dir_q;
  assign busy        = (state_q == ST_UP) || (state_q == ST_DOWN);
  assign done        = (state_q == ST_DONE);
  assign err         = err_q;
  assign dbg_state_o = state_q;

endmodule
